// File: rtl/instr_fetch.sv
`default_nettype none
// ==================================================================
// Module : instr_fetch
// Desc   : In-order instruction fetch with a DEPTH-entry queue and redirect flush.
//          Optional same-cycle response bypass when INSTR_FETCH_BYPASS_EN is defined.
// Rev    : 1.0  initial release
// ==================================================================
module instr_fetch #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam int            c_aw    = $clog2(DEPTH);
  localparam int            c_cw    = $clog2(DEPTH + 1);
  localparam logic [c_cw:0] c_depth = (c_cw + 1)'(DEPTH);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_rsp_pc;
  logic [c_cw-1:0] r_outst;
  logic [c_cw-1:0] r_drop;
  logic [c_cw-1:0] r_count;
  logic [c_aw-1:0] r_wptr;
  logic [c_aw-1:0] r_rptr;
  logic [XLEN-1:0] r_q_pc    [DEPTH];
  logic [31:0]     r_q_instr [DEPTH];

  logic [c_cw:0]   w_inflight;
  logic            w_req_valid;
  logic            w_req_fire;
  logic            w_rsp;
  logic            w_keep;
  logic            w_byp;
  logic            w_out_valid;
  logic            w_push;
  logic            w_pop;

  assign w_inflight  = {1'b0, r_outst} + {1'b0, r_count};
  assign w_req_valid = rst_n && !redirect_valid && (w_inflight < c_depth);
  assign w_req_fire  = w_req_valid && imem_req_ready;

  // Stray responses with nothing outstanding (pre-reset traffic) are ignored.
  assign w_rsp  = imem_rsp_valid && (r_outst != '0);
  assign w_keep = w_rsp && !redirect_valid && (r_drop == '0);

`ifdef INSTR_FETCH_BYPASS_EN
  assign w_byp = w_keep && (r_count == '0);
`else
  assign w_byp = 1'b0;
`endif

  assign w_out_valid = !redirect_valid && ((r_count != '0) || w_byp);
  assign w_pop       = w_out_valid && out_ready && !w_byp;
  assign w_push      = w_keep && !(w_byp && out_ready);

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = {r_pc[XLEN-1:2], 2'b00};
  assign out_valid      = w_out_valid;
  assign out_pc         = w_byp ? r_rsp_pc : r_q_pc[r_rptr];
  assign out_instr      = w_byp ? imem_rsp_data : r_q_instr[r_rptr];

  // r_rsp_pc is the PC of the next response that will be kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc     <= RESET_PC;
      r_rsp_pc <= RESET_PC;
      r_outst  <= '0;
      r_drop   <= '0;
    end else begin
      r_outst <= r_outst + c_cw'(w_req_fire) - c_cw'(w_rsp);
      if (redirect_valid) begin
        r_pc     <= redirect_pc;
        r_rsp_pc <= redirect_pc;
        r_drop   <= r_outst - c_cw'(w_rsp);
      end else begin
        if (w_req_fire) r_pc <= r_pc + XLEN'(4);
        if (w_keep) r_rsp_pc <= r_rsp_pc + XLEN'(4);
        if (w_rsp && (r_drop != '0)) r_drop <= r_drop - c_cw'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_q_pc[i]    <= '0;
        r_q_instr[i] <= '0;
      end
    end else if (redirect_valid) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_q_pc[r_wptr]    <= r_rsp_pc;
        r_q_instr[r_wptr] <= imem_rsp_data;
        r_wptr            <= r_wptr + c_aw'(1);
      end
      if (w_pop) r_rptr <= r_rptr + c_aw'(1);
      r_count <= r_count + c_cw'(w_push) - c_cw'(w_pop);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ==================================================================
// Module : tb_instr_fetch
// Desc   : Directed + randomized bench for instr_fetch against an epoch-tagged model.
// Rev    : 1.0  initial release
// ==================================================================
module tb_instr_fetch;
  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
`ifdef INSTR_FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              imem_req_valid;
  logic              imem_req_ready = 1'b0;
  logic [XLEN-1:0]   imem_req_addr;
  logic              imem_rsp_valid = 1'b0;
  logic [31:0]       imem_rsp_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [XLEN-1:0]   out_pc;
  logic [31:0]       out_instr;
  logic              redirect_valid = 1'b0;
  logic [XLEN-1:0]   redirect_pc = '0;

  instr_fetch #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  req_t        mem_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] reqs[$];
  logic [31:0] popped[$];
  logic [31:0] model_pc;
  int          epoch;
  int          cyc;
  int          n_checks;
  int          n_pass;
  int          lat_min;
  int          lat_max;
  int          rsp_pct;
  int          first_rsp_cyc;
  int          first_ov_cyc;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    imem_req_ready = 1'b0;
    mem_q.delete();
    exp_q.delete();
    reqs.delete();
    popped.delete();
    model_pc      = RESET_PC;
    epoch         = 0;
    first_rsp_cyc = -1;
    first_ov_cyc  = -1;
    @(posedge clk); #1;
    check("rst_req_valid", 64'(imem_req_valid), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_pc", 64'(out_pc), 64'd0);
    check("rst_out_instr", 64'(out_instr), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // One clock cycle: drive at posedge+1, sample and update the model at negedge.
  task automatic step(input bit redir, input logic [31:0] rpc, input bit ordy, input bit qrdy,
                      input bit redir_on_rsp);
    bit   rv;
    bit   kept;
    bit   ev;
    int   before_out;
    int   before_cnt;
    req_t h;
    rv = (mem_q.size() > 0) && (mem_q[0].due <= cyc) && ($urandom_range(99) < rsp_pct);
    imem_rsp_valid = rv;
    imem_rsp_data  = rv ? memfn(mem_q[0].addr) : $urandom;
    redirect_valid = redir || (redir_on_rsp && rv);
    redirect_pc    = rpc;
    out_ready      = ordy;
    imem_req_ready = qrdy;
    @(negedge clk);
    before_out = mem_q.size();
    before_cnt = exp_q.size();
    check("req_valid", 64'(imem_req_valid), 64'(!redirect_valid && (before_out + before_cnt < DEPTH)));
    kept = 1'b0;
    if (rv) begin
      if (first_rsp_cyc < 0) first_rsp_cyc = cyc;
      h = mem_q.pop_front();
      if (!redirect_valid && h.epoch == epoch) begin
        exp_q.push_back(h.addr);
        kept = 1'b1;
      end
    end
    ev = !redirect_valid && (before_cnt > 0 || (BYP && kept));
    check("out_valid", 64'(out_valid), 64'(ev));
    if (out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
    if (ev) begin
      if (out_valid) begin
        check("out_pc", 64'(out_pc), 64'(exp_q[0]));
        check("out_instr", 64'(out_instr), 64'(memfn(exp_q[0])));
      end
      if (out_ready) popped.push_back(exp_q.pop_front());
    end
    if (imem_req_valid && imem_req_ready) begin
      check("req_addr", 64'(imem_req_addr), 64'(model_pc & 32'hFFFF_FFFC));
      mem_q.push_back('{addr: model_pc, epoch: epoch, due: cyc + $urandom_range(lat_max, lat_min)});
      reqs.push_back(imem_req_addr);
      model_pc = model_pc + 32'd4;
    end
    if (redirect_valid) begin
      epoch++;
      exp_q.delete();
      model_pc = rpc;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  initial begin
    bit filled;
    n_checks = 0;
    n_pass   = 0;
    cyc      = 0;
    lat_min  = 1;
    lat_max  = 1;
    rsp_pct  = 100;

    // Zero-wait memory, core always ready.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    check("s1_req_count", 64'(reqs.size()), 64'd4);
    if (reqs.size() == 4) check("s1_req3", 64'(reqs[3]), 64'd12);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    check("s1_pops", 64'(popped.size() >= 3), 64'd1);
    if (popped.size() >= 3) begin
      check("s1_pc0", 64'(popped[0]), 64'd0);
      check("s1_pc1", 64'(popped[1]), 64'd4);
      check("s1_pc2", 64'(popped[2]), 64'd8);
    end

    // Core stalled: queue fills to DEPTH, then resumes at 16.
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("s2_accepted", 64'(reqs.size()), 64'(DEPTH));
    check("s2_req_stall", 64'(imem_req_valid), 64'd0);
    check("s2_out_pc", 64'(out_pc), 64'd0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    check("s2_resume", 64'(reqs.size() > DEPTH), 64'd1);
    if (reqs.size() > DEPTH) check("s2_resume_addr", 64'(reqs[DEPTH]), 64'd16);

    // Redirect with two requests outstanding.
    do_reset();
    lat_min = 3;
    lat_max = 3;
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    popped.delete();
    step(1'b1, 32'h40, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    check("s3_pops", 64'(popped.size() > 0), 64'd1);
    if (popped.size() > 0) check("s3_first_pc", 64'(popped[0]), 64'h40);

    // Redirect coinciding with the only outstanding response.
    do_reset();
    lat_min = 2;
    lat_max = 2;
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    reqs.delete();
    for (int i = 0; i < 3; i++) step(1'b0, 32'h80, 1'b1, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    check("s4_req", 64'(reqs.size()), 64'd1);
    if (reqs.size() > 0) check("s4_req_addr", 64'(reqs[0]), 64'h80);
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("s4_pops", 64'(popped.size()), 64'd1);
    if (popped.size() > 0) check("s4_kept_pc", 64'(popped[0]), 64'h80);

    // Asynchronous reset with three queued entries.
    do_reset();
    lat_min = 1;
    lat_max = 1;
    filled  = 1'b0;
    for (int i = 0; i < 20 && !filled; i++) begin
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);
      filled = (exp_q.size() == 3);
    end
    check("s5_filled", 64'(filled), 64'd1);
    check("s5_pre_out_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("s5_async_out_valid", 64'(out_valid), 64'd0);
    check("s5_async_req_valid", 64'(imem_req_valid), 64'd0);
    do_reset();
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    check("s5_after_req", 64'(reqs.size()), 64'd1);
    if (reqs.size() > 0) check("s5_after_addr", 64'(reqs[0]), 64'(RESET_PC));

    // Response-to-out_valid latency with an empty queue.
    do_reset();
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("s6_latency", 64'(first_ov_cyc - first_rsp_cyc), BYP ? 64'd0 : 64'd1);

    // Randomized traffic.
    do_reset();
    lat_min = 1;
    lat_max = 4;
    rsp_pct = 70;
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(99) < 3, $urandom & 32'hFFFF_FFFC, ($urandom_range(3) != 0),
           ($urandom_range(3) != 0), $urandom_range(99) < 2);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameters (name, default, meaning):
- XLEN, 32, address and PC width.
- DEPTH, 4, queue entries; a power of two, at least 2.
- RESET_PC, 0, first fetch address after reset.

REQ-002 Ports (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  XLEN  word-aligned fetch address.
- imem_rsp_valid  in  1  instruction word returned; responses arrive in order, one per accepted request, at least 1 cycle later.
- imem_rsp_data  in  32  returned instruction word.
- out_valid  out  1  instruction available to the core.
- out_ready  in  1  core consumes it.
- out_pc  out  XLEN  PC of out_instr.
- out_instr  out  32  instruction word.
- redirect_valid  in  1  core requests a fetch redirect (JAL or other taken jump).
- redirect_pc  in  XLEN  new fetch PC.

Function
REQ-003 The block SHALL keep a fetch PC; each accepted request (imem_req_valid && imem_req_ready) SHALL advance it by 4, modulo 2^XLEN.
REQ-004 imem_req_addr SHALL equal the fetch PC with bits [1:0] forced to 0.
REQ-005 imem_req_valid SHALL be high iff (outstanding + queue_count) < DEPTH and redirect_valid is low.
REQ-006 Outstanding SHALL increment on an accepted request and decrement on every imem_rsp_valid, whether the response is kept or dropped.
REQ-007 A kept response SHALL be written into the queue with its request PC; queue order equals request order.
REQ-008 out_valid SHALL be high iff the queue is non-empty and redirect_valid is low; out_pc and out_instr show the head entry.
REQ-009 out_pc and out_instr SHALL stay stable while out_valid && !out_ready.
REQ-010 The head entry SHALL pop on out_valid && out_ready; a push and a pop in the same cycle SHALL leave queue_count unchanged.
REQ-011 On redirect_valid the block SHALL, in that cycle:
- flush the queue;
- load the fetch PC with redirect_pc;
- set drop_cnt to the outstanding count after that cycle's response.
REQ-012 While drop_cnt > 0, each imem_rsp_valid SHALL be discarded and SHALL decrement drop_cnt.
REQ-013 A response arriving in a redirect cycle SHALL be discarded.
REQ-014 Back-to-back redirects SHALL take the last redirect_pc.
REQ-015 The queue SHALL never overflow; by REQ-005, outstanding + queue_count <= DEPTH holds at all times.
REQ-016 Sustained throughput with zero-wait memory and out_ready held high SHALL be 1 instruction per cycle.

Reset
REQ-017 When rst_n is low, regardless of clk:
- fetch PC = RESET_PC;
- queue empty;
- outstanding = 0, drop_cnt = 0;
- imem_req_valid = 0, out_valid = 0;
- out_pc = 0, out_instr = 0.
REQ-018 The first request, to address RESET_PC, SHALL assert in the first cycle after rst_n deasserts.
REQ-019 Reset mid-operation SHALL discard all in-flight state; responses arriving after reset to pre-reset requests are the memory's responsibility and are not tracked.

Configuration
REQ-020 Macro INSTR_FETCH_BYPASS_EN, when defined:
- With the queue empty and no drop pending, a kept response SHALL appear on out_valid, out_pc and out_instr in the same cycle.
- If out_ready is also high, that response SHALL be consumed without being written to the queue.
- Without the macro, every response SHALL be written to the queue first, so minimum response-to-out_valid latency is 1 cycle.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Reset release, zero-wait memory, out_ready=1: request addresses 0, 4, 8, 12 on consecutive cycles; out_pc sequence 0, 4, 8, with out_instr matching memory.
- out_ready=0, memory always ready: exactly DEPTH=4 requests accepted, then imem_req_valid=0; out_pc=0 stays stable; releasing out_ready resumes with address 16.
- Redirect to 0x40 with 2 requests outstanding: the next 2 responses are dropped, and the first out_pc after the redirect is 0x40.
- Redirect in the same cycle as imem_rsp_valid, with 1 request outstanding: the response is dropped, drop_cnt=0, and the next request address is redirect_pc.
- rst_n asserted mid-stream with the queue at 3 entries: out_valid=0 and imem_req_valid=0 immediately (asynchronously); after release the first request address is RESET_PC.
- Queue empty, response arrives: out_valid in the same cycle with INSTR_FETCH_BYPASS_EN defined, one cycle later without it.
